mem_burst_ctrl: RTL and testbench

MEM_BURST_CTRL -- requirements
Module: mem_burst_ctrl

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_rd_skid.sv | 59 +++++
 rtl/mem_burst_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mem_burst_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared types and default sizing for the burst memory controller.
//   state_e         - controller FSM state encoding
//   MEM_DATA_WIDTH  - default memory word width
//   MEM_DEPTH       - default number of memory words
package mem_pkg;

  localparam int MEM_DATA_WIDTH = 8;
  localparam int MEM_DEPTH      = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/mem_rd_skid.sv
// mem_rd_skid: 2-entry read-data buffer between the memory read port and
// the rd_valid/rd_ready stream.
//   clk, rst   - rising-edge clock, synchronous active-high reset
//   push       - write push_data into the tail (ignored when full unless popping)
//   pop        - drop the head entry (ignored when empty)
//   head       - oldest entry, meaningful only when !empty
//   full/empty - occupancy flags
// Push and pop in the same cycle on a full buffer is allowed: the head is
// read before the freed slot is rewritten at the clock edge.
module mem_rd_skid
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = MEM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] slot [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            cnt;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (cnt == 2'd0);
  assign full    = (cnt == 2'd2);
  assign head    = slot[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Data slots carry no reset; cnt alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) slot[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: single-command burst controller in front of a synchronous
// single-port memory.
//   clk, rst                    - rising-edge clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/len - burst command (len = beats - 1)
//   wr_valid/ready/data         - write-data stream, passed straight to memory
//   rd_valid/ready/data         - read-data stream, fed from a 2-entry buffer
//   mem_addr/we/wdata, mem_rdata - memory port; rdata is valid one cycle
//                                 after a read cycle
//   busy                        - controller not idle
//   done                        - one-cycle pulse at burst completion
// Write bursts finish with done in the first IDLE cycle after the last beat.
// Read bursts finish with done in the cycle the last beat leaves the buffer.
module mem_burst_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int DEPTH      = MEM_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done
);

  state_e                state;
  state_e                state_nxt;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [ADDR_WIDTH-1:0] beat_cnt;   // write beats accepted / reads issued
  logic [ADDR_WIDTH-1:0] pop_cnt;    // read beats handed to the consumer
  logic                  vld_pipe;   // a read was issued last cycle
  logic                  done_wr_q;

  logic                  cmd_hs;
  logic                  wr_beat;
  logic                  rd_pop;
  logic                  rd_issue;
  logic                  last_wr;
  logic                  last_issue;
  logic                  last_pop;

  logic                  buf_full;
  logic                  buf_empty;
  logic [DATA_WIDTH-1:0] buf_head;
  logic [1:0]            buf_occ;
  logic [2:0]            slots_used;

  // ---------------------------------------------------------------------------
  // Read buffer
  // ---------------------------------------------------------------------------
  mem_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rd_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (vld_pipe),
    .push_data (mem_rdata),
    .pop       (rd_pop),
    .head      (buf_head),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  // ---------------------------------------------------------------------------
  // Handshakes and burst bookkeeping
  // ---------------------------------------------------------------------------
  assign cmd_hs   = (state == ST_IDLE) && cmd_valid;
  // rst gates the beat so an abort takes effect in the reset cycle itself.
  assign wr_beat  = (state == ST_WRITE) && wr_valid && !rst;
  assign rd_pop   = rd_valid && rd_ready;

  // Slots committed after this cycle: buffered beats, minus the one leaving
  // now, plus the read whose data lands this cycle. Crediting the pop keeps
  // back-to-back reads flowing when the consumer never stalls.
  assign buf_occ    = buf_full ? 2'd2 : {1'b0, ~buf_empty};
  assign slots_used = 3'(buf_occ) - 3'(rd_pop) + 3'(vld_pipe);
  assign rd_issue   = (state == ST_READ) && (slots_used < 3'd2);

  assign last_wr    = wr_beat  && (beat_cnt == len_q);
  assign last_issue = rd_issue && (beat_cnt == len_q);
  // The last pop always lands in DRAIN: data trails its issue by 2+ cycles.
  assign last_pop   = (state == ST_DRAIN) && rd_pop && (pop_cnt == len_q);

  assign addr_nxt = (addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0
                                                       : addr_q + ADDR_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      len_q     <= '0;
      beat_cnt  <= '0;
      pop_cnt   <= '0;
      vld_pipe  <= 1'b0;
      done_wr_q <= 1'b0;
    end else begin
      vld_pipe  <= rd_issue;
      done_wr_q <= last_wr;
      if (cmd_hs) begin
        addr_q   <= cmd_addr;
        len_q    <= cmd_len;
        beat_cnt <= '0;
        pop_cnt  <= '0;
      end else begin
        if (wr_beat || rd_issue) begin
          addr_q   <= addr_nxt;
          beat_cnt <= beat_cnt + ADDR_WIDTH'(1);
        end
        if (rd_pop) pop_cnt <= pop_cnt + ADDR_WIDTH'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cmd_valid)  state_nxt = cmd_write ? ST_WRITE : ST_READ;
      ST_WRITE: if (last_wr)    state_nxt = ST_IDLE;
      ST_READ:  if (last_issue) state_nxt = ST_DRAIN;
      ST_DRAIN: if (last_pop)   state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      ST_WRITE: wr_ready = !rst;
      default: ;
    endcase
    mem_we   = wr_beat;
    rd_valid = !buf_empty && !rst;
    done     = done_wr_q || (last_pop && !rst);
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wr_data;
  assign rd_data   = buf_head;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb_mem_burst_ctrl: randomized and directed bench for mem_burst_ctrl.
// A behavioural memory answers the DUT's memory port; a reference array plus
// write/read scoreboards predict every memory write and every read beat.
module tb_mem_burst_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr, cmd_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_ready;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy, done;

  always #5 clk = ~clk;

  mem_burst_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .done(done)
  );

  // Behavioural synchronous memory
  logic [DW-1:0] bmem [DEPTH];
  always @(posedge clk) begin
    if (mem_we) bmem[mem_addr] <= mem_wdata;
    mem_rdata <= bmem[mem_addr];
  end

  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_beat_t;
  wr_beat_t      exp_wr [$];
  logic [DW-1:0] exp_rd [$];
  logic [DW-1:0] ref_mem [DEPTH];
  wr_beat_t      mon_wb;
  logic [DW-1:0] mon_rd;

  int n_chk = 0, n_err = 0;
  int cyc = 0, done_cnt = 0, hs_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: scoreboards and always-true relations, sampled mid-cycle
  always @(negedge clk) begin
    if (mem_we) begin
      chk("wr_expected", 32'(exp_wr.size() > 0), 32'd1);
      if (exp_wr.size() > 0) begin
        mon_wb = exp_wr.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(mon_wb.addr));
        chk("wr_data", 32'(mem_wdata), 32'(mon_wb.data));
      end
    end
    if (rd_valid && rd_ready) begin
      chk("rd_expected", 32'(exp_rd.size() > 0), 32'd1);
      if (exp_rd.size() > 0) begin
        mon_rd = exp_rd.pop_front();
        chk("rd_data", 32'(rd_data), 32'(mon_rd));
      end
    end
    if (done) done_cnt++;
    if (!rst) begin
      if (cmd_valid && cmd_ready) hs_cnt++;
      chk("cmd_ready_vs_busy", 32'(cmd_ready), 32'(!busy));
      if (!busy) begin
        chk("idle_wr_ready", 32'(wr_ready), 32'd0);
        chk("idle_rd_valid", 32'(rd_valid), 32'd0);
      end
    end
  end

  // Offer a command; returns at posedge+1 of the first cycle after handshake.
  task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [AW-1:0] l,
                          output int hs);
    int t = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    @(negedge clk);
    while (!cmd_ready && t < 2000) begin @(negedge clk); t++; end
    chk("cmd_accept", 32'(cmd_ready), 32'd1);
    hs = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // mode: 0 = wr_valid always 1, 1 = 1,0,1,0..., 2 = random
  task automatic write_burst(input logic [AW-1:0] a, input int len, input int mode);
    logic [DW-1:0] d [$];
    logic [DW-1:0] v;
    int hs, i = 0, t = 0, k = 0, d0;
    for (int j = 0; j <= len; j++) begin
      v = DW'($urandom);
      d.push_back(v);
      exp_wr.push_back(wr_beat_t'{addr: AW'((int'(a) + j) % DEPTH), data: v});
      ref_mem[(int'(a) + j) % DEPTH] = v;
    end
    d0 = done_cnt;
    send_cmd(1'b1, a, AW'(len), hs);
    while (i <= len && t < 20 * (len + 1) + 50) begin
      if (mode == 0)      wr_valid = 1'b1;
      else if (mode == 1) wr_valid = (k % 2 == 0);
      else                wr_valid = 1'($urandom_range(0, 1));
      wr_data = d[i];
      k++;
      @(negedge clk);
      if (wr_valid && wr_ready) i++;
      t++;
      if (i <= len) begin @(posedge clk); #1; end
    end
    chk("wr_beats", i, len + 1);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    @(negedge clk);
    chk("wr_done_pulse", 32'(done), 32'd1);
    chk("wr_busy_after", 32'(busy), 32'd0);
    @(negedge clk);
    chk("wr_done_single", 32'(done), 32'd0);
    chk("wr_done_cnt", done_cnt - d0, 1);
    chk("wr_sb_empty", exp_wr.size(), 0);
  endtask

  // mode: 0 = rd_ready always 1, 1 = 1,0,0,1,0,0..., 2 = random
  task automatic read_burst(input logic [AW-1:0] a, input int len, input int mode);
    int hs, n = 0, t = 0, k = 0, first = -1, last = -1, d0;
    logic done_at_last = 1'b0;
    for (int j = 0; j <= len; j++) exp_rd.push_back(ref_mem[(int'(a) + j) % DEPTH]);
    d0 = done_cnt;
    send_cmd(1'b0, a, AW'(len), hs);
    while (n <= len && t < 20 * (len + 1) + 50) begin
      if (mode == 0)      rd_ready = 1'b1;
      else if (mode == 1) rd_ready = (k % 3 == 0);
      else                rd_ready = 1'($urandom_range(0, 1));
      k++;
      @(negedge clk);
      if (rd_valid && rd_ready) begin
        if (n == 0) first = cyc;
        n++;
        if (n == len + 1) begin last = cyc; done_at_last = done; end
      end
      t++;
      if (n <= len) begin @(posedge clk); #1; end
    end
    chk("rd_beats", n, len + 1);
    chk("rd_done_on_last_pop", 32'(done_at_last), 32'd1);
    if (mode == 0) begin
      // Handshake cycle hs, READ entry hs+1, first beat two cycles later.
      chk("rd_first_latency", first - hs, 3);
      chk("rd_throughput", last - first, len);
    end
    @(posedge clk); #1;
    rd_ready = 1'b0;
    @(negedge clk);
    chk("rd_busy_after", 32'(busy), 32'd0);
    chk("rd_done_cnt", done_cnt - d0, 1);
    chk("rd_sb_empty", exp_rd.size(), 0);
  endtask

  // 5-beat write, reset after the second accepted beat.
  task automatic reset_mid_write(input logic [AW-1:0] a);
    logic [DW-1:0] d [2];
    int hs, i = 0, d0;
    for (int j = 0; j < 2; j++) begin
      d[j] = DW'($urandom);
      exp_wr.push_back(wr_beat_t'{addr: AW'((int'(a) + j) % DEPTH), data: d[j]});
      ref_mem[(int'(a) + j) % DEPTH] = d[j];
    end
    d0 = done_cnt;
    send_cmd(1'b1, a, AW'(4), hs);
    wr_valid = 1'b1;
    for (int j = 0; j < 2; j++) begin
      wr_data = d[j];
      @(negedge clk);
      if (wr_valid && wr_ready) i++;
      @(posedge clk); #1;
    end
    chk("rstw_beats_before", i, 2);
    rst = 1'b1;
    wr_data = DW'($urandom);
    @(negedge clk);
    chk("rstw_no_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstw_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rstw_busy", 32'(busy), 32'd0);
    chk("rstw_mem_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstw_no_done", done_cnt - d0, 0);
    chk("rstw_sb_empty", exp_wr.size(), 0);
  endtask

  // Read stalled until the buffer holds data, then reset discards it.
  task automatic reset_mid_read(input logic [AW-1:0] a);
    int hs, d0;
    d0 = done_cnt;
    rd_ready = 1'b0;
    send_cmd(1'b0, a, AW'(7), hs);
    repeat (5) @(negedge clk);
    chk("rstr_buf_valid", 32'(rd_valid), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstr_valid_in_rst", 32'(rd_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstr_busy", 32'(busy), 32'd0);
    chk("rstr_valid_after", 32'(rd_valid), 32'd0);
    chk("rstr_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rstr_no_done", done_cnt - d0, 0);
  endtask

  // cmd_valid held through a write burst; the follow-up read is taken once.
  task automatic hold_cmd_test(input logic [AW-1:0] a);
    logic [DW-1:0] d [4];
    int i = 0, t = 0, h0, d0;
    for (int j = 0; j < 4; j++) begin
      d[j] = DW'($urandom);
      exp_wr.push_back(wr_beat_t'{addr: AW'((int'(a) + j) % DEPTH), data: d[j]});
      ref_mem[(int'(a) + j) % DEPTH] = d[j];
    end
    for (int j = 0; j < 4; j++) exp_rd.push_back(d[j]);
    h0 = hs_cnt;
    d0 = done_cnt;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = AW'(3);
    @(negedge clk);
    @(posedge clk); #1;
    cmd_write = 1'b0;
    wr_valid  = 1'b1;
    while (i < 4 && t < 50) begin
      wr_data = d[i];
      @(negedge clk);
      chk("hold_ready_low", 32'(cmd_ready), 32'd0);
      if (wr_valid && wr_ready) i++;
      t++;
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    @(negedge clk);
    chk("hold_ready_idle", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rd_ready  = 1'b1;
    t = 0;
    while ((exp_rd.size() > 0 || busy) && t < 100) begin @(negedge clk); t++; end
    chk("hold_rd_drained", exp_rd.size(), 0);
    chk("hold_hs_cnt", hs_cnt - h0, 2);
    chk("hold_done_cnt", done_cnt - d0, 2);
    @(posedge clk); #1;
    rd_ready = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a;
    int len;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    write_burst(AW'(0), DEPTH - 1, 0);        // full-depth burst fills memory
    write_burst(AW'(10'h3FE), 3, 0);          // wraps 3FF -> 000
    read_burst(AW'(10'h3FE), 3, 0);
    read_burst(AW'(100), 7, 1);
    write_burst(AW'(200), 2, 1);
    read_burst(AW'(200), 2, 2);
    write_burst(AW'(5), 0, 0);                // single beat
    read_burst(AW'(5), 0, 0);
    reset_mid_write(AW'(300));
    read_burst(AW'(300), 4, 0);               // only the first 2 beats landed
    reset_mid_read(AW'(400));
    hold_cmd_test(AW'(500));
    read_burst(AW'(0), DEPTH - 1, 0);         // full-depth read

    for (int r = 0; r < 30; r++) begin
      a = AW'($urandom);
      if ($urandom_range(0, 3) == 0) a = AW'(DEPTH - 1 - int'($urandom_range(0, 3)));
      len = int'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) write_burst(a, len, int'($urandom_range(0, 2)));
      else                           read_burst(a, len, int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
